// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first, one bit per clock through a gate-level full adder.
// Latency: start accepted at E0 -> done pulse and sum/cout valid after edge E0+WIDTH.
// Backpressure: none; start is ignored while busy, and is accepted again in the done cycle.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, ps_sh, ps_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last_bit;
    logic             ha0_s, ha0_c, fa_s, ha1_c, fa_c;

    half_adder u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(ha0_s), .c(ha0_c));
    half_adder u_ha1 (.x(ha0_s),   .y(carry),   .s(fa_s),  .c(ha1_c));
    assign fa_c = ha0_c | ha1_c;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Shift-then-overwrite form stays legal for WIDTH=1 as well.
    always_comb begin
        ps_nxt            = ps_sh >> 1;
        ps_nxt[WIDTH-1]   = fa_s;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            ps_sh <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            ps_sh <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (busy) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            ps_sh <= ps_nxt;
            carry <= fa_c;
            cnt   <= cnt + CW'(1);
            // Result registers only move on the final bit so they hold across later runs.
            if (last_bit) begin
                sum  <= ps_nxt;
                cout <= fa_c;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder at WIDTH=16 plus a WIDTH=1 instance.
module tb_serial_adder;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic          cin = 1'b0;
    logic          busy, done, cout;
    logic [W-1:0]  sum;

    logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
    logic busy1, done1, sum1, cout1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] s;
        logic         co;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Ends at the negedge after the accepting edge E0, with start still high.
    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        @(negedge clk);
        start = 1'b1;
        a = va;
        b = vb;
        cin = vc;
        @(posedge clk);
        @(negedge clk);
    endtask

    // k counts negedges after E0; done seen at k means done rose on edge E0+k.
    task automatic wait_done(input int inj_k, input logic [W-1:0] ia, input logic [W-1:0] ib,
                             output int k, output int bcnt);
        k = 0;
        bcnt = 0;
        while (!done && k < 100) begin
            if (busy) bcnt++;
            start = (k == inj_k);
            if (k == inj_k) begin
                a = ia;
                b = ib;
                cin = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int k, bc;
        launch(v.a, v.b, v.cin);
        wait_done(-1, '0, '0, k, bc);
        chk({nm, " latency"}, 64'(k), 64'(W));
        chk({nm, " busy cycles"}, 64'(bc), 64'(W));
        chk({nm, " sum"}, 64'(sum), 64'(v.s));
        chk({nm, " cout"}, 64'(cout), 64'(v.co));
        chk({nm, " busy with done"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({nm, " done width"}, 64'(done), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2, bc, pulses;
        logic [W:0] rs;
        logic [1:0] e1;
        vec_t rv;

        tbl[0] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        tbl[2] = '{16'h1234, 16'hEDCB, 1'b1, 16'h0000, 1'b1};
        tbl[3] = '{16'h1234, 16'hEDCB, 1'b0, 16'hFFFF, 1'b0};
        tbl[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        tbl[5] = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0};
        tbl[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};

        // Reset values, before any clock edge
        #2;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset sum", 64'(sum), 64'd0);
        chk("reset cout", 64'(cout), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Start during RUN must be ignored
        launch(16'h00FF, 16'h0F00, 1'b0);
        wait_done(4, 16'hFFFF, 16'hFFFF, k, bc);
        chk("ignore latency", 64'(k), 64'(W));
        chk("ignore sum", 64'(sum), 64'h0FFF);
        chk("ignore cout", 64'(cout), 64'd0);
        @(negedge clk);
        chk("ignore no restart", 64'(busy), 64'd0);

        // Back-to-back: start accepted in the DONE cycle
        launch(16'h0001, 16'h0002, 1'b0);
        wait_done(-1, '0, '0, k, bc);
        chk("b2b first sum", 64'(sum), 64'h0003);
        start = 1'b1;
        a = 16'h8000;
        b = 16'h8000;
        cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b2b second busy", 64'(busy), 64'd1);
        chk("b2b first held", 64'(sum), 64'h0003);
        wait_done(-1, '0, '0, k2, bc);
        chk("b2b second latency", 64'(k + 1 + k2), 64'd33);
        chk("b2b second sum", 64'(sum), 64'h0000);
        chk("b2b second cout", 64'(cout), 64'd1);
        @(negedge clk);

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Reset asserted mid-run abandons the addition
        launch(16'h1234, 16'h0001, 1'b0);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre-reset sum held", 64'(sum), 64'hFFFF);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun reset busy", 64'(busy), 64'd0);
        chk("midrun reset done", 64'(done), 64'd0);
        chk("midrun reset sum", 64'(sum), 64'd0);
        chk("midrun reset cout", 64'(cout), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        chk("no activity after reset", 64'(pulses), 64'd0);
        rv = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0};
        run_vec(rv, "post-reset");

        for (int i = 0; i < 200; i++) begin
            rv.a = 16'($urandom);
            rv.b = 16'($urandom);
            rv.cin = 1'($urandom);
            rs = 17'(rv.a) + 17'(rv.b) + 17'(rv.cin);
            rv.s = rs[W-1:0];
            rv.co = rs[W];
            run_vec(rv, "rand");
        end

        // WIDTH=1: all eight input combinations
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start1 = 1'b1;
            a1 = i[2];
            b1 = i[1];
            cin1 = i[0];
            e1 = 2'(a1) + 2'(b1) + 2'(cin1);
            @(posedge clk);
            @(negedge clk);
            start1 = 1'b0;
            chk($sformatf("w1 busy %0d", i), 64'(busy1), 64'd1);
            @(negedge clk);
            chk($sformatf("w1 done %0d", i), 64'(done1), 64'd1);
            chk($sformatf("w1 result %0d", i), 64'({cout1, sum1}), 64'(e1));
            @(negedge clk);
            chk($sformatf("w1 done width %0d", i), 64'(done1), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
